packet_width_translator: RTL and testbench
==========================================

Name: packet_width_translator

Overview:
- Store-and-forward packet width converter: accepts 32-bit packet words, emits 64-bit packet beats with byte length on the first beat.
- Discards packets flagged bad, so only good packets leave the block.
- Sits between a 32-bit MAC-side stream (no backpressure) and a 64-bit consumer with a ready signal; single clock domain.

Parameters:
- INPUT_WIDTH, 32, input word width in bits.
- OUTPUT_WIDTH, 64, output beat width; must equal 2*INPUT_WIDTH.
- DATA_DEPTH, 2048, data FIFO depth in output beats; must be a power of 2 and at least 1152, so one 9216-byte packet always fits.
- LEN_DEPTH, 64, packet-descriptor FIFO depth; power of 2.

Ports:
- iclk  in  1  sole clock for input and output sides.
- irst  in  1  asynchronous reset, active-low.
- ivalid  in  1  input word valid.
- isop  in  1  first word of a packet.
- ieop  in  1  last word of a packet.
- iresidual  in  2  valid bytes in the eop word; 0 means all 4 bytes are valid.
- idata  in  INPUT_WIDTH  input word; the first byte is in the MSBs.
- ibad  in  1  packet error; sampled on any valid word of the packet.
- ovalid  out  1  output beat transferred this cycle.
- ohalf_word_valid  out  1  only odata[63:32] is meaningful; asserted only together with ovalid and oeop.
- osop  out  1  first beat of a packet.
- oeop  out  1  last beat of a packet.
- oplen  out  14  packet length in bytes; valid when ovalid & osop.
- odata  out  OUTPUT_WIDTH  output beat.
- obad  out  1  bad indicator.
- oready  in  1  consumer ready.
- ocpu_interrupt  out  1  one-cycle pulse when a packet is discarded.

Behaviour:
- Reset: while irst=0, all outputs are 0, FIFOs are empty, and the packer and drop state are cleared. Reset mid-packet discards the packet.
- Input packing:
  - The first valid word of a packet goes to beat bits [63:32]; the second goes to [31:0]; and so on.
  - Gaps (ivalid=0) are allowed anywhere in a packet.
- Length:
  - A 14-bit counter adds 4 per word.
  - On the eop word it adds 4 if iresidual=0, otherwise adds iresidual.
  - Example: 17 words with iresidual=1 gives 65.
- Bad flag: accumulated by OR of ibad across all words of the packet.
- Commit: on the eop word, if not bad and no overflow occurred:
  - Advance the committed data write pointer.
  - Push the length onto the descriptor FIFO.
- Discard: bad packets are never emitted.
  - Rewind the speculative data write pointer to the committed pointer.
  - Pulse ocpu_interrupt for 1 cycle.
- Overflow: data FIFO full, or descriptor FIFO full at eop.
  - Mark the packet for discard; stop writing its remaining words.
  - Rewind and pulse ocpu_interrupt at its eop.
- Protocol error: isop while a packet is open.
  - Discard the open packet (pulse ocpu_interrupt) and start the new one.
  - Words with ivalid=1 outside a packet are ignored.
- Output availability: only committed data is readable; no beat of a packet is emitted before that packet's eop is committed.
- Output handshake:
  - The output is registered.
  - ovalid may be 1 in cycle N only if oready was 1 in cycle N-1.
  - Every ovalid cycle is a completed transfer; there is no hold/retry semantic.
  - With oready held high and data committed, beats stream back-to-back.
- Latency: first beat appears 2 cycles after the committing eop word, given oready=1.
- Beat flags:
  - osop is set on the first beat, with oplen from the descriptor FIFO.
  - oeop is set on the last beat.
  - A packet with an odd word count ends with a half beat: ohalf_word_valid=1, odata[31:0]=0.
  - A 1-beat packet has osop=oeop=1.
- obad is 0 on every emitted beat in the default build.
- oplen and odata hold their last values when ovalid=0; oplen is don't-care on non-sop beats.
- Simultaneous input write and output read of the FIFO are supported every cycle. Full/empty use pointers 1 bit wider than the address.

Optional Feature:
- Macro: PKT_TRANSLATOR_BAD_FORWARD_EN.
- Defined:
  - Bad packets are committed and forwarded rather than discarded.
  - obad=1 on the eop beat of a bad packet.
  - ocpu_interrupt pulses only on overflow or protocol-error discards.
- Undefined: bad packets are dropped as described in Behaviour; obad is tied to 0.

Test Plan:
- 64-byte packet (16 words, residual 0), oready=1 -> 8 beats; first beat has osop, oplen=64; last beat has oeop, ohalf_word_valid=0; data is word pairs with the first word in bits [63:32].
- 65-byte packet (17 words, eop iresidual=1) -> 9 beats; 9th beat has oeop, ohalf_word_valid=1, odata[31:0]=0; oplen=65.
- Good, bad (ibad on eop word), good packets back to back -> only the two good packets are emitted, in order; ocpu_interrupt pulses exactly once.
- 9216-byte packet with oready toggling randomly (25% low) -> 1152 beats; ovalid never follows an oready=0 cycle; data exact; oplen=9216 on osop.
- Fill to within 100 beats of full with oready=0, then send a 1000-byte packet -> packet discarded, interrupt pulses; after draining, the next good packet passes intact.
- Assert irst mid-packet, release, send a 64-byte packet -> all outputs 0 during reset; only the new packet is emitted, with oplen=64.

Source files
------------

// File: rtl/packet_width_translator.sv
// packet_width_translator: store-and-forward packet width converter.
// Packs 32-bit input words into 64-bit output beats. A packet becomes visible
// on the output only after its eop word has been committed. Errored,
// overflowed and protocol-broken packets are rewound out of the data FIFO.
// Build option: define PKT_TRANSLATOR_BAD_FORWARD_EN to commit and forward
// bad packets (obad on their eop beat) instead of discarding them.
module packet_width_translator #(
  parameter int INPUT_WIDTH  = 32,
  parameter int OUTPUT_WIDTH = 64,
  parameter int DATA_DEPTH   = 2048,
  parameter int LEN_DEPTH    = 64
) (
  input  logic                    iclk,
  input  logic                    irst,
  input  logic                    ivalid,
  input  logic                    isop,
  input  logic                    ieop,
  input  logic [1:0]              iresidual,
  input  logic [INPUT_WIDTH-1:0]  idata,
  input  logic                    ibad,
  output logic                    ovalid,
  output logic                    ohalf_word_valid,
  output logic                    osop,
  output logic                    oeop,
  output logic [13:0]             oplen,
  output logic [OUTPUT_WIDTH-1:0] odata,
  output logic                    obad,
  input  logic                    oready,
  output logic                    ocpu_interrupt
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int LW = $clog2(LEN_DEPTH);
  localparam logic [AW:0] PTR_ONE  = 1;
  localparam logic [LW:0] DESC_ONE = 1;

`ifdef PKT_TRANSLATOR_BAD_FORWARD_EN
  localparam logic BAD_FORWARD = 1'b1;
`else
  localparam logic BAD_FORWARD = 1'b0;
`endif

  // Beat storage and packet descriptors {bad, length}.
  logic [OUTPUT_WIDTH-1:0] data_mem [DATA_DEPTH];
  logic [14:0]             desc_mem [LEN_DEPTH];

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_spec, wr_commit, rd_ptr;
  logic [LW:0] desc_wr, desc_rd;

  // Packer state for the packet currently being received.
  logic                   pkt_open, have_hi, bad_acc, ovf_acc;
  logic [13:0]            len_cnt;
  logic [INPUT_WIDTH-1:0] hi_word;

  logic                    accept, start, perr, cur_half, cur_bad, cur_ovf;
  logic                    need_write, data_full, desc_full, write_ok;
  logic                    ovf_word, bad_final, commit, drop_eop;
  logic [AW:0]             base_ptr, wr_next;
  logic [13:0]             cur_len, new_len;
  logic [2:0]              len_add;
  logic [OUTPUT_WIDTH-1:0] beat;

  // Per-word decisions: packing, length, overflow, commit or discard.
  // NOTE: every signal here is assigned on every path, so no latch is inferred.
  always_comb begin
    accept     = ivalid & (isop | pkt_open);
    start      = ivalid & isop;
    perr       = start & pkt_open;
    // A protocol error abandons the open packet: the new one builds from the committed pointer.
    base_ptr   = perr ? wr_commit : wr_spec;
    cur_len    = start ? 14'd0 : len_cnt;
    cur_bad    = start ? 1'b0 : bad_acc;
    cur_ovf    = start ? 1'b0 : ovf_acc;
    cur_half   = start ? 1'b0 : have_hi;
    len_add    = (ieop && iresidual != 2'd0) ? {1'b0, iresidual} : 3'd4;
    new_len    = cur_len + {11'd0, len_add};
    need_write = accept & (cur_half | ieop);
    beat       = cur_half ? {hi_word, idata} : {idata, {INPUT_WIDTH{1'b0}}};
    data_full  = (base_ptr[AW] != rd_ptr[AW]) && (base_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    desc_full  = (desc_wr[LW] != desc_rd[LW]) && (desc_wr[LW-1:0] == desc_rd[LW-1:0]);
    write_ok   = need_write & ~cur_ovf & ~data_full;
    ovf_word   = cur_ovf | (need_write & data_full);
    bad_final  = cur_bad | ibad;
    commit     = accept & ieop & ~ovf_word & ~desc_full & (BAD_FORWARD | ~bad_final);
    drop_eop   = accept & ieop & ~commit;
    wr_next    = base_ptr + (write_ok ? PTR_ONE : '0);
  end

  // Input side state: packer, speculative/committed pointers, discard pulse.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      pkt_open       <= 1'b0;
      have_hi        <= 1'b0;
      bad_acc        <= 1'b0;
      ovf_acc        <= 1'b0;
      len_cnt        <= 14'd0;
      hi_word        <= '0;
      wr_spec        <= '0;
      wr_commit      <= '0;
      desc_wr        <= '0;
      ocpu_interrupt <= 1'b0;
    end else begin
      if (accept) begin
        pkt_open <= ~ieop;
        len_cnt  <= new_len;
        bad_acc  <= bad_final;
        ovf_acc  <= ovf_word;
        have_hi  <= ~ieop & ~cur_half;
        if (!cur_half) hi_word <= idata;
      end
      wr_spec <= drop_eop ? wr_commit : wr_next;
      if (commit) begin
        wr_commit <= wr_next;
        desc_wr   <= desc_wr + DESC_ONE;
      end
      ocpu_interrupt <= perr | drop_eop;
    end
  end

  // FIFO storage writes.
  // NOTE: storage arrays are not reset; the pointers alone define valid contents.
  always_ff @(posedge iclk) begin
    if (write_ok) data_mem[base_ptr[AW-1:0]] <= beat;
    if (commit)   desc_mem[desc_wr[LW-1:0]]  <= {bad_final, new_len};
  end

  // Descriptor at the head of the queue and the beat geometry it implies.
  logic [14:0] head;
  logic [12:0] head_words;
  logic [11:0] head_beats;
  logic        desc_empty;

  // Word and beat counts of the next committed packet, from its byte length.
  always_comb begin
    head       = desc_mem[desc_rd[LW-1:0]];
    head_words = 13'(({1'b0, head[13:0]} + 15'd3) >> 2);
    head_beats = 12'(({1'b0, head_words} + 14'd1) >> 1);
    desc_empty = (desc_wr == desc_rd);
  end

  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;
  rd_state_t   rd_state;
  logic [11:0] beats_left;
  logic        last_half, last_bad;

  // Output FSM: one registered beat per cycle that followed oready=1.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      rd_state         <= RD_IDLE;
      rd_ptr           <= '0;
      desc_rd          <= '0;
      beats_left       <= 12'd0;
      last_half        <= 1'b0;
      last_bad         <= 1'b0;
      ovalid           <= 1'b0;
      ohalf_word_valid <= 1'b0;
      osop             <= 1'b0;
      oeop             <= 1'b0;
      oplen            <= 14'd0;
      odata            <= '0;
      obad             <= 1'b0;
    end else begin
      ovalid           <= 1'b0;
      ohalf_word_valid <= 1'b0;
      osop             <= 1'b0;
      oeop             <= 1'b0;
      obad             <= 1'b0;
      case (rd_state)
        RD_IDLE: begin
          if (oready && !desc_empty) begin
            ovalid  <= 1'b1;
            osop    <= 1'b1;
            oplen   <= head[13:0];
            odata   <= data_mem[rd_ptr[AW-1:0]];
            rd_ptr  <= rd_ptr + PTR_ONE;
            desc_rd <= desc_rd + DESC_ONE;
            if (head_beats == 12'd1) begin
              oeop             <= 1'b1;
              ohalf_word_valid <= head_words[0];
              obad             <= BAD_FORWARD & head[14];
            end else begin
              beats_left <= head_beats - 12'd1;
              last_half  <= head_words[0];
              last_bad   <= head[14];
              rd_state   <= RD_STREAM;
            end
          end
        end
        RD_STREAM: begin
          if (oready) begin
            ovalid     <= 1'b1;
            odata      <= data_mem[rd_ptr[AW-1:0]];
            rd_ptr     <= rd_ptr + PTR_ONE;
            beats_left <= beats_left - 12'd1;
            if (beats_left == 12'd1) begin
              oeop             <= 1'b1;
              ohalf_word_valid <= last_half;
              obad             <= BAD_FORWARD & last_bad;
              rd_state         <= RD_IDLE;
            end
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_width_translator.sv
// Self-checking bench for packet_width_translator (default build).
// Expected beats come from a packet-level model: each accepted packet's words
// are paired into beats and queued; the output monitor pops and compares.
module tb_packet_width_translator;

  logic        iclk = 1'b0;
  logic        irst = 1'b0;
  logic        ivalid = 1'b0, isop = 1'b0, ieop = 1'b0, ibad = 1'b0;
  logic [1:0]  iresidual = 2'd0;
  logic [31:0] idata = 32'd0;
  logic        oready = 1'b0;
  logic        ovalid, ohalf_word_valid, osop, oeop, obad, ocpu_interrupt;
  logic [13:0] oplen;
  logic [63:0] odata;

  packet_width_translator dut (
    .iclk(iclk), .irst(irst), .ivalid(ivalid), .isop(isop), .ieop(ieop),
    .iresidual(iresidual), .idata(idata), .ibad(ibad),
    .ovalid(ovalid), .ohalf_word_valid(ohalf_word_valid), .osop(osop), .oeop(oeop),
    .oplen(oplen), .odata(odata), .obad(obad), .oready(oready),
    .ocpu_interrupt(ocpu_interrupt)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    logic [63:0] data;
    bit          sop;
    bit          eop;
    bit          half;
    int          plen;
  } beat_t;

  typedef struct {
    int nbytes;
    int bad_at;   // word index carrying ibad, -1 for none
    bit emit;
    int plen;
    int beats;
    bit half;
    int irq;
  } vec_t;

  beat_t exp_q[$];
  beat_t e;
  int    checks = 0, errors = 0;
  int    cyc = 0;
  int    ready_mode = 1;   // 0: low, 1: high, 2: random 25% low
  bit    prev_ready = 1'b0;
  int    pkts_out = 0, irq_cnt = 0, last_plen = 0, last_beats = 0, cur_beats = 0;
  bit    last_half = 1'b0;
  int    sop_cyc = 0, eop_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge iclk) cyc <= cyc + 1;

  always @(posedge iclk) begin
    #1;
    case (ready_mode)
      0:       oready = 1'b0;
      1:       oready = 1'b1;
      default: oready = ($urandom_range(3) != 0);
    endcase
  end

  // Output monitor: compares every transferred beat against the model queue.
  always @(negedge iclk) begin
    if (irst) begin
      if (ocpu_interrupt) irq_cnt++;
      if (ohalf_word_valid) check("half_without_valid_eop", ovalid & oeop, 1);
      if (ovalid) begin
        check("valid_after_ready_low", prev_ready, 1);
        if (exp_q.size() == 0) check("unexpected_beat", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check("odata", odata, e.data);
          check("osop", osop, e.sop);
          check("oeop", oeop, e.eop);
          check("ohalf", ohalf_word_valid, e.half);
          check("obad", obad, 0);
          if (e.sop) check("oplen", oplen, e.plen);
        end
        if (osop) begin
          cur_beats = 0;
          sop_cyc   = cyc;
          last_plen = oplen;
        end
        cur_beats++;
        if (oeop) begin
          pkts_out++;
          last_beats = cur_beats;
          last_half  = ohalf_word_valid;
        end
      end
    end
    prev_ready = oready;
  end

  task automatic idle();
    @(posedge iclk); #1;
    ivalid = 1'b0; isop = 1'b0; ieop = 1'b0; ibad = 1'b0;
  endtask

  // Sends one packet; when it is expected out, its beats go to the model queue.
  task automatic send_pkt(input int nbytes, input int bad_at, input int gap_pct, input bit expect_out);
    int          nw = (nbytes + 3) / 4;
    logic [31:0] w[$];
    beat_t       b;
    for (int i = 0; i < nw; i++) w.push_back($urandom);
    if (expect_out) begin
      for (int i = 0; i < nw; i += 2) begin
        b.data = {w[i], (i + 1 < nw) ? w[i+1] : 32'd0};
        b.sop  = (i == 0);
        b.eop  = (i + 2 >= nw);
        b.half = (i + 1 >= nw);
        b.plen = nbytes;
        exp_q.push_back(b);
      end
    end
    for (int i = 0; i < nw; i++) begin
      while ($urandom_range(99) < gap_pct) idle();
      @(posedge iclk); #1;
      ivalid    = 1'b1;
      isop      = (i == 0);
      ieop      = (i == nw - 1);
      iresidual = (i == nw - 1) ? 2'(nbytes % 4) : 2'd0;
      idata     = w[i];
      ibad      = (i == bad_at);
      if (i == nw - 1) eop_cyc = cyc;
    end
  endtask

  // Opens a packet and sends words without ever closing it.
  task automatic send_partial(input int nw);
    for (int i = 0; i < nw; i++) begin
      @(posedge iclk); #1;
      ivalid = 1'b1; isop = (i == 0); ieop = 1'b0; ibad = 1'b0;
      idata  = $urandom;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    idle();
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge iclk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    repeat (5) @(posedge iclk);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, ovalid | ohalf_word_valid | osop | oeop | obad | ocpu_interrupt |
                (|oplen) | (|odata), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   p0, q0, ngood, nbad, nb, bad_at;
    bit   bad;

    vecs[0] = '{64, -1, 1, 64, 8, 0, 0};
    vecs[1] = '{65, -1, 1, 65, 9, 1, 0};
    vecs[2] = '{4,  -1, 1, 4,  1, 1, 0};
    vecs[3] = '{8,  -1, 1, 8,  1, 0, 0};
    vecs[4] = '{1,  -1, 1, 1,  1, 1, 0};
    vecs[5] = '{64,  3, 0, 0,  0, 0, 1};
    vecs[6] = '{12, -1, 1, 12, 2, 1, 0};
    vecs[7] = '{10, -1, 1, 10, 2, 1, 0};
    vecs[8] = '{9,   2, 0, 0,  0, 0, 1};

    ready_mode = 1;
    repeat (3) @(negedge iclk);
    check_outputs_zero("reset_outputs");
    @(posedge iclk); #1;
    irst = 1'b1;
    repeat (3) @(posedge iclk);

    // Table of single packets with oready held high.
    for (int i = 0; i < 9; i++) begin
      p0 = pkts_out;
      q0 = irq_cnt;
      send_pkt(vecs[i].nbytes, vecs[i].bad_at, 0, vecs[i].emit);
      wait_drain(500);
      check($sformatf("vec%0d_pkts", i), pkts_out - p0, vecs[i].emit);
      check($sformatf("vec%0d_irq", i), irq_cnt - q0, vecs[i].irq);
      if (vecs[i].emit) begin
        check($sformatf("vec%0d_plen", i), last_plen, vecs[i].plen);
        check($sformatf("vec%0d_beats", i), last_beats, vecs[i].beats);
        check($sformatf("vec%0d_half", i), last_half, vecs[i].half);
      end
    end

    // Commit-to-first-beat latency.
    send_pkt(16, -1, 0, 1);
    wait_drain(200);
    check("latency", sop_cyc - eop_cyc, 2);

    // Good, bad (ibad on eop word), good back to back.
    p0 = pkts_out; q0 = irq_cnt;
    send_pkt(64, -1, 0, 1);
    send_pkt(64, 15, 0, 0);
    send_pkt(40, -1, 0, 1);
    wait_drain(500);
    check("b2b_pkts", pkts_out - p0, 2);
    check("b2b_irq", irq_cnt - q0, 1);
    check("b2b_last_plen", last_plen, 40);

    // Jumbo packet with input gaps and oready 25% low.
    ready_mode = 2;
    send_pkt(9216, -1, 10, 1);
    wait_drain(30000);
    check("jumbo_beats", last_beats, 1152);
    check("jumbo_plen", last_plen, 9216);
    ready_mode = 1;

    // Fill to 100 beats short of full, then overflow with a 1000-byte packet.
    ready_mode = 0;
    p0 = pkts_out; q0 = irq_cnt;
    send_pkt(9216, -1, 0, 1);
    send_pkt(6368, -1, 0, 1);
    send_pkt(1000, -1, 0, 0);
    idle();
    repeat (5) @(posedge iclk);
    check("ovf_irq", irq_cnt - q0, 1);
    check("ovf_held_while_not_ready", pkts_out - p0, 0);
    ready_mode = 1;
    wait_drain(5000);
    check("ovf_drained_pkts", pkts_out - p0, 2);
    check("ovf_drained_plen", last_plen, 6368);
    send_pkt(64, -1, 0, 1);
    wait_drain(500);
    check("ovf_after_pkts", pkts_out - p0, 3);
    check("ovf_after_plen", last_plen, 64);

    // Protocol error (isop while open) and stray words outside a packet.
    p0 = pkts_out; q0 = irq_cnt;
    send_partial(5);
    send_pkt(16, -1, 0, 1);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(posedge iclk); #1;
      ivalid = 1'b1; isop = 1'b0; ieop = (i == 2); idata = $urandom;
    end
    wait_drain(500);
    check("perr_irq", irq_cnt - q0, 1);
    check("perr_pkts", pkts_out - p0, 1);
    check("perr_plen", last_plen, 16);

    // Reset mid-packet with a committed packet still queued.
    ready_mode = 0;
    send_pkt(32, -1, 0, 0);
    send_partial(6);
    @(posedge iclk); #1;
    irst = 1'b0; ivalid = 1'b0; isop = 1'b0; ieop = 1'b0;
    repeat (2) @(negedge iclk);
    check_outputs_zero("mid_reset_outputs");
    ready_mode = 1;
    @(posedge iclk); #1;
    irst = 1'b1;
    p0 = pkts_out;
    send_pkt(64, -1, 0, 1);
    wait_drain(500);
    check("post_reset_pkts", pkts_out - p0, 1);
    check("post_reset_plen", last_plen, 64);

    // Randomized packets against the model.
    ready_mode = 2;
    p0 = pkts_out; q0 = irq_cnt;
    ngood = 0; nbad = 0;
    for (int i = 0; i < 40; i++) begin
      nb     = $urandom_range(300, 1);
      bad    = ($urandom_range(4) == 0);
      bad_at = bad ? $urandom_range((nb + 3) / 4 - 1) : -1;
      if (bad) nbad++;
      else ngood++;
      send_pkt(nb, bad_at, 20, !bad);
    end
    wait_drain(20000);
    check("rand_pkts", pkts_out - p0, ngood);
    check("rand_irq", irq_cnt - q0, nbad);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
